// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 scancode decoder.
//   ps2_state_e  - prefix-decoder states
//   ps2_event_t  - one FIFO entry {extended, released, code}
//   Code*        - protocol byte values (prefixes and keyboard replies)
//   PauseLen     - bytes that follow E1 in the Pause/Break sequence
//   is_reply()   - true for bytes that are keyboard replies, not key codes
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk,
        StPause
    } ps2_state_e;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } ps2_event_t;

    localparam int unsigned EntryW = 10;

    localparam logic [7:0] CodeE0 = 8'hE0;  // extended prefix
    localparam logic [7:0] CodeF0 = 8'hF0;  // break prefix
    localparam logic [7:0] CodeE1 = 8'hE1;  // pause sequence start
    localparam logic [7:0] CodeFa = 8'hFA;  // ACK
    localparam logic [7:0] CodeAa = 8'hAA;  // self-test passed
    localparam logic [7:0] CodeEe = 8'hEE;  // echo
    localparam logic [7:0] CodeFe = 8'hFE;  // resend
    localparam logic [7:0] CodeFc = 8'hFC;  // self-test failed
    localparam logic [7:0] Code00 = 8'h00;  // key detection error
    localparam logic [7:0] CodeFf = 8'hFF;  // key detection error

    localparam logic [2:0] PauseLen = 3'd7;

    function automatic logic is_reply(input logic [7:0] b);
        return (b == CodeFa) || (b == CodeAa) || (b == CodeEe) || (b == CodeFe) ||
               (b == CodeFc) || (b == Code00) || (b == CodeFf);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: show-ahead FIFO of decoded key events.
//   clk, reset   - system clock, synchronous active-high reset
//   push, wdata  - write request and entry
//   pop          - remove head; ignored while empty
//   head         - current head entry, zero while empty
//   valid        - FIFO non-empty
//   drop         - one-cycle: a push was refused because the FIFO was full
// A push on a full FIFO is still accepted when a pop happens in the same cycle.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [EntryW-1:0] wdata,
    input  logic              pop,
    output logic [EntryW-1:0] head,
    output logic              valid,
    output logic              drop
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic [EntryW-1:0] mem_q [FIFO_DEPTH];

    logic empty;
    logic full;
    logic pop_ok;
    logic push_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & full & ~pop_ok;

    assign valid = ~empty;
    assign head  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
        end
    end

    // Storage needs no reset: entries are only visible once written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: turns raw PS/2 bytes into make/break key events.
//   clk, reset          - system clock, synchronous active-high reset
//   data                - received byte
//   data_ready          - byte strobe; a byte is taken on its 0->1 edge
//   data_valid          - framing/parity OK for the strobed byte
//   evt_code/extended/released/valid - FIFO head (show-ahead), zero when empty
//   evt_pop             - consume the head event
//   reply_code          - last keyboard reply byte (FA, AA, EE, FE, FC, 00, FF)
//   reply_strobe        - one-cycle pulse when reply_code updates
//   rx_error            - one-cycle pulse on a strobed byte with data_valid=0
//   overflow            - sticky: an event was dropped on a full FIFO
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       data_ready,
    input  logic       data_valid,
    output logic [7:0] evt_code,
    output logic       evt_extended,
    output logic       evt_released,
    output logic       evt_valid,
    input  logic       evt_pop,
    output logic [7:0] reply_code,
    output logic       reply_strobe,
    output logic       rx_error,
    output logic       overflow
);

    ps2_state_e state_q;
    logic [2:0] skip_q;
    logic       data_ready_q;
    logic       strobe;

    logic       push;
    ps2_event_t push_evt;
    ps2_event_t head_evt;
    logic       fifo_drop;

    assign strobe = data_ready & ~data_ready_q;

    // Push is decoded combinationally so the event is written on the same
    // edge that samples the terminating byte.
    always_comb begin
        push     = 1'b0;
        push_evt = '0;
        if (strobe && data_valid) begin
            case (state_q)
                StIdle: begin
                    if (data != CodeE0 && data != CodeF0 && data != CodeE1 &&
                        !is_reply(data)) begin
                        push          = 1'b1;
                        push_evt.code = data;
                    end
                end
                StExt: begin
                    if (data != CodeF0 && data != CodeE0) begin
                        push          = 1'b1;
                        push_evt.ext  = 1'b1;
                        push_evt.code = data;
                    end
                end
                StBrk: begin
                    push          = 1'b1;
                    push_evt.rel  = 1'b1;
                    push_evt.code = data;
                end
                StExtBrk: begin
                    push          = 1'b1;
                    push_evt.ext  = 1'b1;
                    push_evt.rel  = 1'b1;
                    push_evt.code = data;
                end
                StPause: begin
                    // The last skipped byte completes Pause, reported as E1.
                    if (skip_q == 3'd1) begin
                        push          = 1'b1;
                        push_evt.code = CodeE1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            skip_q       <= '0;
            data_ready_q <= 1'b0;
            reply_code   <= '0;
            reply_strobe <= 1'b0;
            rx_error     <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            data_ready_q <= data_ready;
            reply_strobe <= 1'b0;
            rx_error     <= 1'b0;
            if (fifo_drop) begin
                overflow <= 1'b1;
            end
            if (strobe) begin
                if (!data_valid) begin
                    // A corrupt byte abandons any prefix or pause in progress.
                    rx_error <= 1'b1;
                    state_q  <= StIdle;
                    skip_q   <= '0;
                end else begin
                    case (state_q)
                        StIdle: begin
                            if (data == CodeE0) begin
                                state_q <= StExt;
                            end else if (data == CodeF0) begin
                                state_q <= StBrk;
                            end else if (data == CodeE1) begin
                                state_q <= StPause;
                                skip_q  <= PauseLen;
                            end else if (is_reply(data)) begin
                                reply_code   <= data;
                                reply_strobe <= 1'b1;
                            end
                        end
                        StExt: begin
                            if (data == CodeF0) begin
                                state_q <= StExtBrk;
                            end else if (data != CodeE0) begin
                                state_q <= StIdle;
                            end
                        end
                        StBrk, StExtBrk: begin
                            state_q <= StIdle;
                        end
                        StPause: begin
                            if (skip_q == 3'd1) begin
                                state_q <= StIdle;
                                skip_q  <= '0;
                            end else begin
                                skip_q <= skip_q - 3'd1;
                            end
                        end
                        default: begin
                            state_q <= StIdle;
                            skip_q  <= '0;
                        end
                    endcase
                end
            end
        end
    end

    ps2_event_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .wdata(push_evt),
        .pop  (evt_pop),
        .head (head_evt),
        .valid(evt_valid),
        .drop (fifo_drop)
    );

    assign evt_code     = head_evt.code;
    assign evt_extended = head_evt.ext;
    assign evt_released = head_evt.rel;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench: a queue-based reference model runs alongside the DUT and
// every output is compared each cycle; directed sequences pin literal results.
module tb_ps2_scancode_decoder;

    localparam int Depth = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic       data_ready;
    logic       data_valid;
    logic [7:0] evt_code;
    logic       evt_extended;
    logic       evt_released;
    logic       evt_valid;
    logic       evt_pop;
    logic [7:0] reply_code;
    logic       reply_strobe;
    logic       rx_error;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ps2_scancode_decoder #(
        .FIFO_DEPTH(Depth)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data        (data),
        .data_ready  (data_ready),
        .data_valid  (data_valid),
        .evt_code    (evt_code),
        .evt_extended(evt_extended),
        .evt_released(evt_released),
        .evt_valid   (evt_valid),
        .evt_pop     (evt_pop),
        .reply_code  (reply_code),
        .reply_strobe(reply_strobe),
        .rx_error    (rx_error),
        .overflow    (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [9:0] mq[$];          // {ext, rel, code}
    logic       m_prev;
    logic       m_reply_strobe;
    logic       m_rx_error;
    logic       m_ovf;
    logic [7:0] m_reply_code;
    bit         m_e0;
    bit         m_f0;
    int         m_pause;
    bit         m_push;
    logic [9:0] m_evt;

    function automatic bit reply_byte(input logic [7:0] b);
        return b == 8'hFA || b == 8'hAA || b == 8'hEE || b == 8'hFE ||
               b == 8'hFC || b == 8'h00 || b == 8'hFF;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_prev = 1'b0; m_reply_strobe = 1'b0; m_rx_error = 1'b0; m_ovf = 1'b0;
            m_reply_code = 8'h00; m_e0 = 0; m_f0 = 0; m_pause = 0;
        end else begin
            m_reply_strobe = 1'b0;
            m_rx_error = 1'b0;
            m_push = 0;
            if (data_ready && !m_prev) begin
                if (!data_valid) begin
                    m_rx_error = 1'b1;
                    m_e0 = 0; m_f0 = 0; m_pause = 0;
                end else if (m_pause > 0) begin
                    m_pause--;
                    if (m_pause == 0) begin m_push = 1; m_evt = {2'b00, 8'hE1}; end
                end else if (m_f0) begin
                    m_push = 1; m_evt = {m_e0, 1'b1, data};
                    m_e0 = 0; m_f0 = 0;
                end else if (m_e0) begin
                    if (data == 8'hF0) m_f0 = 1;
                    else if (data != 8'hE0) begin
                        m_push = 1; m_evt = {2'b10, data}; m_e0 = 0;
                    end
                end else if (data == 8'hE0) m_e0 = 1;
                else if (data == 8'hF0) m_f0 = 1;
                else if (data == 8'hE1) m_pause = 7;
                else if (reply_byte(data)) begin
                    m_reply_code = data; m_reply_strobe = 1'b1;
                end else begin
                    m_push = 1; m_evt = {2'b00, data};
                end
            end
            if (evt_pop && mq.size() > 0) void'(mq.pop_front());
            if (m_push) begin
                if (mq.size() < Depth) mq.push_back(m_evt);
                else m_ovf = 1'b1;
            end
            m_prev = data_ready;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [9:0] exp_head;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_head = (mq.size() > 0) ? mq[0] : 10'd0;
            check("evt_valid", evt_valid, mq.size() > 0);
            check("evt_code", evt_code, exp_head[7:0]);
            check("evt_extended", evt_extended, exp_head[9]);
            check("evt_released", evt_released, exp_head[8]);
            check("reply_code", reply_code, m_reply_code);
            check("reply_strobe", reply_strobe, m_reply_strobe);
            check("rx_error", rx_error, m_rx_error);
            check("overflow", overflow, m_ovf);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] b, input logic v, input int hold);
        @(negedge clk); #1;
        data = b; data_valid = v; data_ready = 1'b1;
        repeat (hold) @(negedge clk);
        #1 data_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); #1 reset = 1'b1;
        @(negedge clk); #1 reset = 1'b0;
    endtask

    task automatic pop1();
        @(negedge clk); #1 evt_pop = 1'b1;
        @(negedge clk); #1 evt_pop = 1'b0;
    endtask

    // Pops until empty; reports how many events were seen and the last code.
    task automatic drain(output int cnt, output logic [7:0] last);
        cnt = 0; last = 8'h00;
        for (int i = 0; i < Depth + 3; i++) begin
            @(negedge clk); #1;
            if (evt_valid) begin
                cnt++; last = evt_code; evt_pop = 1'b1;
            end else begin
                evt_pop = 1'b0;
            end
        end
        evt_pop = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'hE1, 8'hFA, 8'hAA, 8'h1C,
                              8'h75, 8'h14, 8'h77, 8'h00, 8'hFF, 8'h5A};

    initial begin
        int         cnt;
        logic [7:0] last;
        logic [7:0] seq [8];

        reset = 1'b1; data = 8'h00; data_ready = 1'b0; data_valid = 1'b1; evt_pop = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        check("rst_evt_valid", evt_valid, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_reply_code", reply_code, 8'h00);

        // 1C, F0 1C
        send(8'h1C, 1'b1, 1);
        check("make_valid_lat1", evt_valid, 1'b1);
        check("make_code", {evt_extended, evt_released, evt_code}, 10'h01C);
        send(8'hF0, 1'b1, 1);
        send(8'h1C, 1'b1, 1);
        pop1();
        check("break_evt", {evt_extended, evt_released, evt_code}, 10'h11C);
        pop1();
        check("empty_after_pops", evt_valid, 1'b0);

        // E0 F0 75
        send(8'hE0, 1'b1, 1);
        check("e0_no_evt", evt_valid, 1'b0);
        send(8'hF0, 1'b1, 1);
        check("e0f0_no_evt", evt_valid, 1'b0);
        send(8'h75, 1'b1, 1);
        check("ext_break_evt", {evt_extended, evt_released, evt_code}, 10'h375);
        drain(cnt, last);
        check("ext_break_count", cnt, 1);

        // Pause/Break sequence
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 8; i++) send(seq[i], 1'b1, 1);
        check("pause_evt", {evt_extended, evt_released, evt_code}, 10'h0E1);
        drain(cnt, last);
        check("pause_count", cnt, 1);
        send(8'h1C, 1'b1, 1);
        check("idle_after_pause", {evt_extended, evt_released, evt_code}, 10'h01C);
        pop1();

        // Corrupt byte after E0, then reply byte
        send(8'hE0, 1'b1, 1);
        send(8'h33, 1'b0, 1);
        check("rx_error_pulse", rx_error, 1'b1);
        send(8'h1C, 1'b1, 1);
        check("after_error_evt", {evt_extended, evt_released, evt_code}, 10'h01C);
        pop1();
        send(8'hFA, 1'b1, 1);
        check("reply_strobe", reply_strobe, 1'b1);
        check("reply_code_fa", reply_code, 8'hFA);
        check("reply_no_evt", evt_valid, 1'b0);

        // Overflow and push+pop on a full FIFO
        do_reset();
        for (int i = 0; i < Depth; i++) send(8'h10 + 8'(i), 1'b1, 1);
        check("full_no_ovf", overflow, 1'b0);
        send(8'h10 + 8'(Depth), 1'b1, 1);
        check("overflow_set", overflow, 1'b1);
        check("ovf_head", evt_code, 8'h10);
        @(negedge clk); #1;
        data = 8'h30; data_valid = 1'b1; data_ready = 1'b1; evt_pop = 1'b1;
        @(negedge clk); #1 data_ready = 1'b0; evt_pop = 1'b0;
        check("pushpop_head", evt_code, 8'h11);
        drain(cnt, last);
        check("pushpop_count", cnt, Depth);
        check("pushpop_last", last, 8'h30);

        // Held strobe, reset mid-prefix
        send(8'h1C, 1'b1, 5);
        drain(cnt, last);
        check("held_strobe_count", cnt, 1);
        send(8'hE0, 1'b1, 1);
        do_reset();
        send(8'h1C, 1'b1, 1);
        check("reset_mid_prefix", {evt_extended, evt_released, evt_code}, 10'h01C);
        pop1();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            reset = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 1) == 0) begin
                data_ready = ~data_ready;
                if (data_ready) begin
                    data = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
                    data_valid = ($urandom_range(0, 15) != 0);
                end
            end
            evt_pop = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk); #1;
        reset = 1'b0; data_ready = 1'b0; evt_pop = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
